sockit_spi_slv: RTL

- Single-lane SPI slave serializer/deserializer. It is the responder at the far end of the SPI master serializer.
- Pin-level SCLK, SS and MOSI are oversampled in the system clock domain. Complete received bytes go to an input queue; transmit bytes come from an output queue and are shifted out on MISO.
- Sits between SPI pads and the queue/FIFO layer, reusing the same valid/ready queue convention as the master path.

---
 rtl/sockit_spi_slv.sv | 187 ++++++++++++++++++
 1 files changed

// File: rtl/sockit_spi_slv.sv
// SPI slave serializer: oversampled SCLK/SS/MOSI in, byte queues to
// the FIFO layer, MISO driven from a single-entry transmit buffer.
module sockit_spi_slv #(
  parameter int SDW = 8,
  parameter int SDL = 3,
  parameter int QCI = 4
) (
  input  logic           clk,
  input  logic           rst,
  input  logic [31:0]    spi_cfg,
  input  logic           quo_vld,
  input  logic [SDW-1:0] quo_dat,
  output logic           quo_rdy,
  output logic           qui_vld,
  output logic [QCI-1:0] qui_ctl,
  output logic [SDW-1:0] qui_dat,
  input  logic           qui_rdy,
  input  logic           spi_sclk_i,
  input  logic           spi_ss_i,
  input  logic [3:0]     spi_sio_i,
  output logic [3:0]     spi_sio_o,
  output logic [3:0]     spi_sio_e,
  output logic           sts_udr,
  output logic           sts_ovf
);

  typedef enum logic {IDLE, ACTIVE} state_t;

  state_t st, st_n;

  logic [2:0]     sclk_s, ss_s;
  logic [1:0]     mosi_s;
  logic           pha_q, pol_q, dir_q;
  logic           pha, pol, dir;
  logic [SDL-1:0] cnt;
  logic [SDW-1:0] rx_sr, tx_sr, buf_dat;
  logic [SDW-1:0] rx_n, tx_adv, ld_dat;
  logic           buf_vld, miso, new_f, ovf_p;
  logic           idle, act, lead, trail;
  logic           smp, shf, done, start, ld;
  logic           quo_xfer, udr, drop, ss_fall;
  logic           ld_first, tx_first, tx_next;
  logic           unused;

  assign unused = ^{spi_cfg[31:7], spi_cfg[5:2], spi_sio_i[3:1]};

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      sclk_s <= '0;
      ss_s   <= '0;
      mosi_s <= '0;
    end else begin
      sclk_s <= {sclk_s[1:0], spi_sclk_i};
      ss_s   <= {ss_s[1:0], spi_ss_i};
      mosi_s <= {mosi_s[0], spi_sio_i[0]};
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) st <= IDLE;
    else      st <= st_n;
  end

  always_comb begin
    st_n = st;
    unique case (st)
      IDLE:   if (ss_s[1] && !ss_s[2]) st_n = ACTIVE;
      ACTIVE: if (!ss_s[1]) st_n = IDLE;
      default: st_n = IDLE;
    endcase
  end

  // cfg is live while idle so the frame-start clk already uses it
  assign idle = (st == IDLE);
  assign pha  = idle ? spi_cfg[0] : pha_q;
  assign pol  = idle ? spi_cfg[1] : pol_q;
  assign dir  = idle ? spi_cfg[6] : dir_q;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      pha_q <= 1'b0;
      pol_q <= 1'b0;
      dir_q <= 1'b0;
    end else if (idle) begin
      pha_q <= spi_cfg[0];
      pol_q <= spi_cfg[1];
      dir_q <= spi_cfg[6];
    end
  end

  assign act     = (st == ACTIVE) && ss_s[1];
  assign ss_fall = (st == ACTIVE) && !ss_s[1];
  assign lead    = (sclk_s[2] == pol) && (sclk_s[1] != pol);
  assign trail   = (sclk_s[2] != pol) && (sclk_s[1] == pol);
  assign smp     = act && (pha ? trail : lead);
  assign shf     = act && (pha ? lead : trail);
  assign done    = smp && (cnt == SDL'(SDW-1));
  assign start   = idle && ss_s[1] && !ss_s[2];
  assign ld      = start || done;

  assign quo_rdy  = !buf_vld;
  assign quo_xfer = quo_vld && !buf_vld;
  assign ld_dat   = buf_vld ? buf_dat : (quo_xfer ? quo_dat : '1);
  assign udr      = ld && !buf_vld && !quo_xfer;
  assign drop     = done && qui_vld && !qui_rdy;

  assign rx_n = dir ? {rx_sr[SDW-2:0], mosi_s[1]}
                    : {mosi_s[1], rx_sr[SDW-1:1]};
  assign tx_adv = dir ? {tx_sr[SDW-2:0], 1'b0}
                      : {1'b0, tx_sr[SDW-1:1]};
  assign ld_first = dir ? ld_dat[SDW-1] : ld_dat[0];
  assign tx_first = dir ? tx_sr[SDW-1] : tx_sr[0];
  assign tx_next  = dir ? tx_sr[SDW-2] : tx_sr[1];

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      cnt   <= '0;
      rx_sr <= '0;
    end else begin
      if (start || ss_fall) cnt <= '0;
      else if (smp)         cnt <= cnt + SDL'(1);
      if (smp) rx_sr <= rx_n;
    end
  end

  // a shift edge at count 0 presents the freshly loaded first bit
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      tx_sr <= '0;
      miso  <= 1'b0;
    end else if (ld) begin
      tx_sr <= ld_dat;
      if (!pha) miso <= ld_first;
    end else if (shf) begin
      if (cnt == '0) begin
        miso <= tx_first;
      end else begin
        tx_sr <= tx_adv;
        miso  <= tx_next;
      end
    end else if (ss_fall) begin
      miso <= 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      buf_vld <= 1'b0;
      buf_dat <= '0;
    end else if (ld) begin
      buf_vld <= 1'b0;
    end else if (quo_xfer) begin
      buf_vld <= 1'b1;
      buf_dat <= quo_dat;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      qui_vld <= 1'b0;
      qui_dat <= '0;
      qui_ctl <= QCI'(4'b0001);
      new_f   <= 1'b0;
      ovf_p   <= 1'b0;
      sts_udr <= 1'b0;
      sts_ovf <= 1'b0;
    end else begin
      sts_udr <= udr;
      sts_ovf <= drop;
      if (done && !drop) begin
        qui_vld <= 1'b1;
        qui_dat <= rx_n;
        qui_ctl <= QCI'({new_f, ovf_p, 2'b01});
      end else if (qui_vld && qui_rdy) begin
        qui_vld <= 1'b0;
      end
      if (start)              new_f <= 1'b1;
      else if (done && !drop) new_f <= 1'b0;
      if (drop)      ovf_p <= 1'b1;
      else if (done) ovf_p <= 1'b0;
    end
  end

  assign spi_sio_o = {2'b00, miso, 1'b0};
  assign spi_sio_e = {2'b00, ss_s[1], 1'b0};

endmodule
